// File: rtl/scrambler_gen.sv
// -----------------------------------------------------------------------------
// scrambler_gen
//   Parametrised 10GBASE-R self-synchronous scrambler / descrambler using the
//   polynomial G(x) = 1 + x^39 + x^58. One payload beat is processed per clock
//   behind a single valid/ready output register stage. The sync header travels
//   alongside the payload untouched.
//
//   Optional feature macro: SCR_TEST_PATTERN_EN
//     When defined, the test_en port exists. test_en=1 forces all-zero payload
//     and scramble mode internally, which produces the pseudo-random test
//     pattern. When undefined, there is no test_en port and no extra logic.
//
// Ports
//   clk         in   clock
//   rst         in   asynchronous reset, active-low
//   mode        in   0 = scramble, 1 = descramble (sampled per accepted beat)
//   seed_load   in   pulse: load seed_value into the LFSR (blocks input that cycle)
//   seed_value  in   58-bit LFSR seed
//   in_data     in   payload, bit 0 first on the wire
//   in_hdr      in   sync header, passed through
//   in_valid    in   input beat valid
//   in_ready    out  input beat accepted when in_valid & in_ready
//   out_data    out  (de)scrambled payload
//   out_hdr     out  header aligned with out_data
//   out_valid   out  output beat valid
//   out_ready   in   downstream accepts when out_valid & out_ready
//   test_en     in   (SCR_TEST_PATTERN_EN only) force test-pattern generation
// -----------------------------------------------------------------------------
module scrambler_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          HDR_WIDTH  = 2,
  parameter logic [57:0] RESET_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  seed_load,
  input  logic [57:0]           seed_value,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SCR_TEST_PATTERN_EN
  ,
  input  logic                  test_en
`endif
);

  // Unrolled bit-serial recurrence. S[0] is the newest bit; each payload bit
  // is combined with taps S[38] and S[57], then the feedback bit (scrambled
  // bit when scrambling, received bit when descrambling) is shifted in.
  // Returns {next_state, payload_out}.
  function automatic logic [57+DATA_WIDTH:0] scramble_beat(
    input logic [57:0]           state,
    input logic [DATA_WIDTH-1:0] d,
    input logic                  descr
  );
    logic [57:0]           s;
    logic [DATA_WIDTH-1:0] o;
    s = state;
    o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o[i] = d[i] ^ s[38] ^ s[57];
      s    = {s[56:0], (descr ? d[i] : o[i])};
    end
    return {s, o};
  endfunction

  logic [57:0]           lfsr;
  logic [57:0]           lfsr_next;
  logic [DATA_WIDTH-1:0] beat_out;
  logic [DATA_WIDTH-1:0] eff_data;
  logic                  eff_mode;
  logic                  accept;

  // Select the payload and mode actually fed to the scrambler core.
  always_comb begin
    eff_data = in_data;
    eff_mode = mode;
`ifdef SCR_TEST_PATTERN_EN
    if (test_en) begin
      eff_data = '0;
      eff_mode = 1'b0;
    end else begin
      eff_data = in_data;
      eff_mode = mode;
    end
`endif
  end

  // Scramble the current beat and compute the LFSR state that follows it.
  always_comb begin
    lfsr_next = lfsr;
    beat_out  = '0;
    {lfsr_next, beat_out} = scramble_beat(lfsr, eff_data, eff_mode);
  end

  // Handshake: accept when the output slot is free or being drained; a seed
  // load steals the cycle so the new seed applies cleanly to the next beat.
  always_comb begin
    in_ready = rst & ~seed_load & (~out_valid | out_ready);
    accept   = in_valid & in_ready;
  end

  // LFSR and output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= RESET_SEED;
      out_data  <= '0;
      out_hdr   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (seed_load) begin
        lfsr <= seed_value;
      end else if (accept) begin
        lfsr <= lfsr_next;
      end else begin
        lfsr <= lfsr;
      end

      if (accept) begin
        out_data  <= beat_out;
        out_hdr   <= in_hdr;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        // Backpressure: hold the registered beat until it is taken.
        out_valid <= out_valid;
      end
    end
  end

endmodule
